// File: rtl/ahb_mem_arbiter.sv
// Round-robin arbiter sharing one AHB-lite memory port between instruction fetch and
// load/store. One transfer at a time, wait-state timeout, registered responses.
module ahb_mem_arbiter #(
  parameter int unsigned TIMEOUT  = 8,
  parameter logic [7:0]  ROM_BASE = 8'hA0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic [31:0] inst_rdata,
  output logic        inst_done,
  output logic        inst_err,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic        data_write,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic [31:0] data_rdata,
  output logic        data_done,
  output logic        data_err,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [31:0] hwdata,
  output logic [1:0]  htrans,
  output logic [3:0]  hprot,
  input  logic        hready,
  input  logic        hresp,
  input  logic [31:0] hrdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [3:0] HPROT_FETCH   = 4'b0000;
  localparam logic [3:0] HPROT_DATA    = 4'b0001;
  localparam logic [7:0] TO_LAST       = 8'(TIMEOUT - 1);

  state_t      state_q;
  owner_t      owner_q, last_owner_q;
  logic [7:0]  cnt_q;
  logic        err_q;
  logic [31:0] wdata_q, haddr_q, hwdata_q, inst_rdata_q, data_rdata_q;
  logic        hwrite_q;
  logic [1:0]  htrans_q;
  logic [3:0]  hprot_q;
  logic        inst_gnt_q, inst_done_q, inst_err_q;
  logic        data_gnt_q, data_done_q, data_err_q;

  logic grant_data, bad_fetch, data_fin, fin_err;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    grant_data = data_req && (!inst_req || last_owner_q == OWN_INST);
    bad_fetch  = inst_addr[31:24] != ROM_BASE;
    data_fin   = hready || cnt_q == TO_LAST;
    fin_err    = hready ? hresp : 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_INST;
      last_owner_q <= OWN_INST;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      wdata_q      <= '0;
      haddr_q      <= '0;
      hwdata_q     <= '0;
      hwrite_q     <= 1'b0;
      htrans_q     <= HTRANS_IDLE;
      hprot_q      <= HPROT_FETCH;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_gnt_q   <= 1'b0;
      inst_done_q  <= 1'b0;
      inst_err_q   <= 1'b0;
      data_gnt_q   <= 1'b0;
      data_done_q  <= 1'b0;
      data_err_q   <= 1'b0;
    end else begin
      inst_gnt_q  <= 1'b0;
      inst_done_q <= 1'b0;
      inst_err_q  <= 1'b0;
      data_gnt_q  <= 1'b0;
      data_done_q <= 1'b0;
      data_err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (inst_req || data_req) begin
            state_q <= ADDR;
            if (grant_data) begin
              owner_q    <= OWN_DATA;
              data_gnt_q <= 1'b1;
              haddr_q    <= data_addr;
              hwrite_q   <= data_write;
              wdata_q    <= data_wdata;
              hprot_q    <= HPROT_DATA;
              htrans_q   <= HTRANS_NONSEQ;
              err_q      <= 1'b0;
            end else begin
              // An out-of-region fetch spends its grant cycle with the bus idle.
              owner_q    <= OWN_INST;
              inst_gnt_q <= 1'b1;
              haddr_q    <= inst_addr;
              hwrite_q   <= 1'b0;
              wdata_q    <= '0;
              hprot_q    <= HPROT_FETCH;
              htrans_q   <= bad_fetch ? HTRANS_IDLE : HTRANS_NONSEQ;
              err_q      <= bad_fetch;
            end
          end
        end
        ADDR: begin
          htrans_q <= HTRANS_IDLE;
          if (err_q) begin
            state_q    <= RESP;
            inst_err_q <= 1'b1;
          end else begin
            state_q  <= DATA;
            hwdata_q <= wdata_q;
          end
        end
        DATA: begin
          if (data_fin) begin
            if (hready && !hwrite_q) begin
              if (owner_q == OWN_DATA) data_rdata_q <= hrdata;
              else                     inst_rdata_q <= hrdata;
            end
            err_q       <= fin_err;
            inst_done_q <= owner_q == OWN_INST && !fin_err;
            inst_err_q  <= owner_q == OWN_INST &&  fin_err;
            data_done_q <= owner_q == OWN_DATA && !fin_err;
            data_err_q  <= owner_q == OWN_DATA &&  fin_err;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            hprot_q     <= HPROT_FETCH;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP: begin
          last_owner_q <= owner_q;
          cnt_q        <= '0;
          err_q        <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign inst_gnt   = inst_gnt_q;
  assign inst_rdata = inst_rdata_q;
  assign inst_done  = inst_done_q;
  assign inst_err   = inst_err_q;
  assign data_gnt   = data_gnt_q;
  assign data_rdata = data_rdata_q;
  assign data_done  = data_done_q;
  assign data_err   = data_err_q;
  assign haddr      = haddr_q;
  assign hwrite     = hwrite_q;
  assign hwdata     = hwdata_q;
  assign htrans     = htrans_q;
  assign hprot      = hprot_q;

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Scoreboard bench for ahb_mem_arbiter: a small AHB slave model with programmable wait
// states, per-transfer latency/bus checks and a completion monitor popping expectations.
module tb_ahb_mem_arbiter;
  localparam int TIMEOUT = 8;

  logic        clk, reset;
  logic        inst_req, inst_gnt, inst_done, inst_err;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_write, data_gnt, data_done, data_err;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hwrite, hready, hresp;
  logic [1:0]  htrans;
  logic [3:0]  hprot;

  ahb_mem_arbiter #(.TIMEOUT(TIMEOUT), .ROM_BASE(8'hA0)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rdata(inst_rdata), .inst_done(inst_done), .inst_err(inst_err),
    .data_req(data_req), .data_addr(data_addr), .data_write(data_write),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rdata(data_rdata),
    .data_done(data_done), .data_err(data_err),
    .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata), .htrans(htrans), .hprot(hprot),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  typedef struct {
    bit          is_data;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] m_inst_rdata = '0;
  logic [31:0] m_data_rdata = '0;

  int          cfg_waits = 0;
  bit          cfg_resp  = 1'b0;
  logic [31:0] cfg_rdata = '0;
  bit          pend      = 1'b0;
  int          wl        = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave: after a NONSEQ address phase, hold hready low for cfg_waits cycles, then respond.
  initial begin
    hready = 1'b0; hresp = 1'b0; hrdata = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        pend = 1'b0; hready = 1'b0; hresp = 1'b0;
      end else if (htrans == 2'b10) begin
        pend = 1'b1; wl = cfg_waits; hready = 1'b0; hresp = 1'b0;
      end else if (pend) begin
        if (wl == 0) begin
          hready = 1'b1; hresp = cfg_resp; hrdata = cfg_rdata; pend = 1'b0;
        end else begin
          hready = 1'b0; hresp = 1'b0; wl--;
        end
      end else begin
        hready = 1'b0; hresp = 1'b0; hrdata = 32'h0BAD_0BAD;
      end
    end
  end

  task automatic pop_cmp(input bit is_data, input bit done, input bit err,
                         input logic [31:0] rdata);
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_completion", 1, 0);
    end else begin
      e = sb.pop_front();
      check("owner", is_data, e.is_data);
      check("err_flag", err, e.err);
      check("rdata", rdata, e.rdata);
      check("done_and_err", done && err, 0);
    end
  endtask

  // Completion monitor, sampling on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (inst_gnt || data_gnt) check("one_gnt", inst_gnt && data_gnt, 0);
        if (inst_done || inst_err) pop_cmp(1'b0, inst_done, inst_err, inst_rdata);
        if (data_done || data_err) pop_cmp(1'b1, data_done, data_err, data_rdata);
      end
    end
  end

  task automatic run_one(input string tag, input bit is_data, input logic [31:0] addr,
                         input bit wr, input logic [31:0] wd, input int waits,
                         input bit resp, input logic [31:0] rd,
                         input int exp_lat, input bit exp_err);
    exp_t e;
    bit   bad, capt, saw_nonseq, g, f;
    int   t0, gnt_lat, fin_lat;
    bad  = !is_data && addr[31:24] != 8'hA0;
    capt = !bad && waits < TIMEOUT && !(is_data && wr);
    cfg_waits = waits; cfg_resp = resp; cfg_rdata = rd;
    if (capt) begin
      if (is_data) m_data_rdata = rd;
      else         m_inst_rdata = rd;
    end
    e.is_data = is_data;
    e.err     = exp_err;
    e.rdata   = is_data ? m_data_rdata : m_inst_rdata;
    sb.push_back(e);

    @(negedge clk);
    if (is_data) begin
      data_req = 1'b1; data_addr = addr; data_write = wr; data_wdata = wd;
    end else begin
      inst_req = 1'b1; inst_addr = addr;
    end
    t0 = cyc; saw_nonseq = 1'b0; gnt_lat = -1; fin_lat = -1;
    for (int k = 0; k < 300 && fin_lat < 0; k++) begin
      @(negedge clk);
      g = is_data ? data_gnt : inst_gnt;
      f = is_data ? (data_done || data_err) : (inst_done || inst_err);
      if (htrans == 2'b10) saw_nonseq = 1'b1;
      if (g) begin
        gnt_lat = cyc - t0;
        check({tag, "_htrans_addr"}, htrans, bad ? 2'b00 : 2'b10);
        if (!bad) begin
          check({tag, "_haddr"}, haddr, addr);
          check({tag, "_hwrite"}, hwrite, is_data && wr);
          check({tag, "_hprot"}, hprot, is_data ? 4'b0001 : 4'b0000);
        end
      end
      if (!bad && cyc - t0 == 2) begin
        check({tag, "_htrans_data"}, htrans, 2'b00);
        if (is_data && wr) check({tag, "_hwdata"}, hwdata, wd);
      end
      if (f) fin_lat = cyc - t0;
    end
    check({tag, "_gnt_lat"}, gnt_lat, 1);
    check({tag, "_fin_lat"}, fin_lat, exp_lat);
    check({tag, "_nonseq_seen"}, saw_nonseq, !bad);
    inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {inst_gnt, inst_done, inst_err, data_gnt, data_done, data_err,
                          hwrite, htrans, hprot}, '0);
    check({tag, "_haddr"}, haddr, '0);
    check({tag, "_hwdata"}, hwdata, '0);
    check({tag, "_rdata"}, {inst_rdata, data_rdata}, '0);
  endtask

  task automatic contention();
    exp_t e;
    int   fins;
    cfg_waits = 0; cfg_resp = 1'b0; cfg_rdata = 32'h7777_0001;
    m_inst_rdata = cfg_rdata; m_data_rdata = cfg_rdata;
    for (int i = 0; i < 4; i++) begin
      e.is_data = (i % 2) == 0; e.err = 1'b0; e.rdata = cfg_rdata;
      sb.push_back(e);
    end
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'hA000_0100;
    data_req = 1'b1; data_addr = 32'hB000_0200; data_write = 1'b0;
    fins = 0;
    for (int k = 0; k < 200 && fins < 4; k++) begin
      @(negedge clk);
      if (inst_done || inst_err || data_done || data_err) fins++;
    end
    check("contention_completions", fins, 4);
    inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_addr = '0; data_write = 1'b0; data_wdata = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    run_one("fetch",    1'b0, 32'hA000_0010, 1'b0, '0,            2,   1'b0, 32'h0051_3093, 5,  1'b0);
    run_one("store",    1'b1, 32'hB000_0004, 1'b1, 32'hDEAD_BEEF, 0,   1'b0, 32'h1111_1111, 3,  1'b0);
    run_one("load",     1'b1, 32'hB000_0008, 1'b0, '0,            1,   1'b0, 32'h1234_5678, 4,  1'b0);
    run_one("badfetch", 1'b0, 32'hB000_0000, 1'b0, '0,            0,   1'b0, 32'h2222_2222, 2,  1'b1);
    run_one("timeout",  1'b1, 32'hB000_000C, 1'b0, '0,            100, 1'b0, 32'h3333_3333, 10, 1'b1);
    run_one("hresp",    1'b1, 32'hB000_0010, 1'b0, '0,            0,   1'b1, 32'hCAFE_F00D, 3,  1'b1);

    // Reset during the DATA phase of a stalled load.
    cfg_waits = 100;
    @(negedge clk);
    data_req = 1'b1; data_addr = 32'hB000_0020; data_write = 1'b0;
    for (int k = 0; k < 20 && !data_gnt; k++) @(negedge clk);
    check("rst_mid_gnt_seen", data_gnt, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    m_inst_rdata = '0; m_data_rdata = '0;
    data_req = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("rst_hold");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    contention();
    run_one("post_rst_fetch", 1'b0, 32'hA000_0040, 1'b0, '0, 2, 1'b0, 32'h00A0_0513, 5, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_mem_arbiter.md
Name: ahb_mem_arbiter

Overview:
- Shares the single AHB-lite memory port of the multicycle core between two requesters: the instruction fetch unit and the load/store unit.
- Sits between the core and slave_glue. It drives haddr, hwrite, hwdata, htrans and hprot, and consumes hready, hresp and hrdata.
- Arbitrates round-robin, runs one transfer at a time, and enforces a wait-state timeout.
- Returns registered read data and a one-cycle done/err pulse to the granted requester.

Parameters:
- TIMEOUT, 8: maximum cycles in DATA with hready low before the transfer is aborted with an error; legal range 2..255.
- ROM_BASE, 8'hA0: haddr[31:24] tag required for instruction fetches; any other tag raises inst_err without a bus access.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_req  in  1  fetch request; held high until inst_done or inst_err.
- inst_addr  in  32  fetch address; stable while inst_req is high.
- inst_gnt  out  1  one-cycle pulse when the fetch wins arbitration.
- inst_rdata  out  32  fetched word; valid in the cycle of inst_done, held until the next fetch completes.
- inst_done  out  1  one-cycle completion pulse.
- inst_err  out  1  one-cycle error pulse (bad region, hresp, or timeout).
- data_req  in  1  load/store request; held until data_done or data_err.
- data_addr  in  32  load/store address.
- data_write  in  1  1 = store, 0 = load.
- data_wdata  in  32  store data.
- data_gnt  out  1  one-cycle pulse when the data request wins arbitration.
- data_rdata  out  32  load data; valid with data_done and held afterwards.
- data_done  out  1  one-cycle completion pulse.
- data_err  out  1  one-cycle error pulse (hresp or timeout).
- haddr  out  32  bus address.
- hwrite  out  1  bus direction.
- hwdata  out  32  bus write data.
- htrans  out  2  2'b10 NONSEQ in ADDR, 2'b00 IDLE otherwise.
- hprot  out  4  4'b0000 for fetch (opcode), 4'b0001 for data.
- hready  in  1  slave ready.
- hresp  in  1  slave error.
- hrdata  in  32  slave read data.

Behaviour:
- Reset: every output is 0, and the state goes to IDLE.
  - Internal: last_owner = INST, so data wins the first tie; the timeout counter is 0; latched address, wdata and owner are 0.
  - Reset mid-transfer aborts immediately. No done/err pulse is issued and the bus returns to htrans = IDLE.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - If exactly one request is high, grant it.
  - If both are high, grant the requester that is not last_owner.
  - On a grant, latch owner, address, write and wdata (write forced 0 for inst), pulse the matching gnt, and go to ADDR.
  - If the granted request is inst and inst_addr[31:24] != ROM_BASE, skip the bus: go to RESP with the error flag set.
- ADDR (1 cycle): drive haddr, hwrite, hprot and htrans = NONSEQ from the latches, then go to DATA.
- DATA:
  - htrans = IDLE. haddr, hwrite and hprot stay held; hwdata = latched wdata.
  - The timeout counter increments each cycle that hready = 0.
  - hready = 1: capture hrdata into the owner's rdata register when it is a read, set error = hresp, go to RESP.
  - Counter reaches TIMEOUT: set error = 1, leave rdata unchanged, go to RESP.
- RESP (1 cycle):
  - Pulse the owner's done when error = 0, or err when error = 1; never both.
  - Update last_owner, clear the counter, go to IDLE.
- Latency: request high at cycle t in IDLE gives gnt at t+1 (ADDR) and done at t+3 minimum, when hready = 1 in the first DATA cycle.
  - With slave_glue's 2-cycle wait, done arrives at t+5.
- A request that drops before its grant is simply not served. Dropping after the grant is illegal and is ignored: the transfer completes.
- Only one transfer is outstanding at a time. A new request during ADDR/DATA/RESP waits for IDLE.
- The request still pending at RESP is granted on the next IDLE cycle, so round-robin alternates under continuous contention.

Test Plan:
- Single fetch: inst_req = 1, inst_addr = 32'hA000_0010, hready low 2 cycles then high with hrdata = 32'h0051_3093.
  - Expect inst_gnt at t+1, htrans = 2'b10 at t+1, inst_done at t+5, inst_rdata = 32'h0051_3093, hprot = 4'b0000.
- Store: data_req = 1, data_write = 1, data_addr = 32'hB000_0004, data_wdata = 32'hDEAD_BEEF, hready = 1.
  - Expect hwrite = 1, hwdata = 32'hDEAD_BEEF in DATA, data_done at t+3, hprot = 4'b0001.
- Contention: both requests held continuously after reset.
  - Expect the grant order data, inst, data, inst; no cycle with both gnt high.
- Bad fetch region: inst_addr = 32'hB000_0000.
  - Expect inst_err at t+2, htrans never NONSEQ, inst_rdata unchanged.
- Timeout and error:
  - hready held 0 with TIMEOUT = 8: expect data_err 8 cycles after entering DATA, no data_done.
  - Separately, hresp = 1 with hready = 1: expect data_err.
- Reset mid-transfer: assert reset during DATA.
  - Expect all outputs 0 in the same cycle, no done/err, and a fresh request after release served normally.
